// File: rtl/adder_pkg.sv
// Shared types and elaboration-time helpers for the multi-cycle add/subtract unit.
package adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned n_chunks(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Counter is never narrower than one bit, even when a single chunk covers the word.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit chunk_fits(input int unsigned width, input int unsigned chunk);
        return (width >= 1) && (chunk >= 1) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple slice; also reports the carry into its MSB for overflow detection.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    localparam int unsigned TW = CHUNK + 1;

    logic [CHUNK:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + TW'(i_cin);
    assign o_sum   = w_total[CHUNK-1:0];
    assign o_cout  = w_total[CHUNK];
    // Carry into the MSB falls out of the MSB sum bit and its two operand bits.
    assign o_c_msb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ o_sum[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract: one CHUNK slice per RUN cycle, LSB first, behind a start/busy/done handshake.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N     = n_chunks(WIDTH, CHUNK);
    localparam int unsigned CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    generate
        if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
            $error("multicycle_adder: CHUNK must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_step;
    logic             w_finish;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_shamt;
    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic             w_slice_cmsb;
    logic [WIDTH-1:0] w_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_finish     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Select the active slice and merge its sum back into the accumulator image.
    always_comb begin
        w_shamt   = 32'(r_cnt) * 32'(CHUNK);
        w_a_slice = CHUNK'(r_a >> w_shamt);
        w_b_slice = CHUNK'(r_b >> w_shamt);
        w_result  = (r_acc & ~(WIDTH'({CHUNK{1'b1}}) << w_shamt))
                  | (WIDTH'(w_slice_sum) << w_shamt);
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .i_a     (w_a_slice),
        .i_b     (w_b_slice),
        .i_cin   (r_carry),
        .o_sum   (w_slice_sum),
        .o_cout  (w_slice_cout),
        .o_c_msb (w_slice_cmsb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            busy <= (w_next_state == RUN);
            done <= w_finish;
            // Subtraction is a + ~b + !borrow, so invert b and the carry once at capture.
            if (w_accept) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub ? ~cin : cin;
                r_cnt   <= '0;
                r_acc   <= '0;
            end
            if (w_step) begin
                r_acc   <= w_result;
                r_carry <= w_slice_cout;
                if (!w_finish) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_finish) begin
                sum  <= w_result;
                cout <= w_slice_cout;
                ovf  <= w_slice_cmsb ^ w_slice_cout;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboarded random/directed bench for multicycle_adder plus small parameter-sweep instances.
module tb_multicycle_adder;

    localparam int N8 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst_n;
    logic        start, cin, sub, busy, done, cout, ovf;
    logic [7:0]  a, b, sum;

    logic        s16_start, s16_cin, s16_sub, s16_busy, s16_done, s16_cout, s16_ovf;
    logic [15:0] s16_a, s16_b, s16_sum;

    logic        s4_start, s4_cin, s4_sub, s4_busy, s4_done, s4_cout, s4_ovf;
    logic [3:0]  s4_a, s4_b, s4_sum;

    multicycle_adder #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    multicycle_adder #(.WIDTH(16), .CHUNK(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16_start), .a(s16_a), .b(s16_b), .cin(s16_cin),
        .sub(s16_sub), .busy(s16_busy), .done(s16_done), .sum(s16_sum), .cout(s16_cout),
        .ovf(s16_ovf)
    );

    multicycle_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .a(s4_a), .b(s4_b), .cin(s4_cin),
        .sub(s4_sub), .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout),
        .ovf(s4_ovf)
    );

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers: returns {ovf, cout, sum[15:0]}.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                           input logic icin, input logic isub);
        longint m, ua, ub, r, sa, sb, s, c;
        logic   rc, ro;
        logic [15:0] rs;
        m  = longint'(1) << w;
        ua = longint'(ia) & (m - 1);
        ub = longint'(ib) & (m - 1);
        c  = longint'(icin);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (isub) begin
            r  = ua - ub - c;
            rc = (r >= 0);
            s  = sa - sb - c;
        end else begin
            r  = ua + ub + c;
            rc = (r >= m);
            s  = sa + sb + c;
        end
        ro = (s < -(m / 2)) || (s >= m / 2);
        rs = 16'(((r % m) + m) % m);
        return {ro, rc, rs};
    endfunction

    // Monitor: every done must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (done !== 1'b0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=%b expected no pending result (t=%0t)", done, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("done_latency", 32'(cyc), 32'(e.due));
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%b expected 0 within 100 cycles", busy);
        end
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                         input logic isub, input bit poke, input bit push);
        logic [17:0] r;
        exp_t        e;
        wait_idle();
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        if (push) begin
            r     = ref_op(8, {8'h00, ia}, {8'h00, ib}, icin, isub);
            e.sum = r[7:0];
            e.cout = r[16];
            e.ovf = r[17];
            e.due = cyc + 1 + N8;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        if (poke) begin
            a = 8'h11; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic icin, input logic isub);
        logic [17:0] r;
        int t0;
        int n = 0;
        r = ref_op(16, ia, ib, icin, isub);
        s16_a = ia; s16_b = ib; s16_cin = icin; s16_sub = isub; s16_start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        s16_start = 1'b0;
        s16_a = 16'($urandom); s16_b = 16'($urandom);
        while (s16_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (s16_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL w16_timeout: got no done expected done within 40 cycles");
        end else begin
            check("w16_latency", 32'(cyc - t0), 32'd16);
            check("w16_sum", 32'(s16_sum), 32'(r[15:0]));
            check("w16_cout", 32'(s16_cout), 32'(r[16]));
            check("w16_ovf", 32'(s16_ovf), 32'(r[17]));
        end
        @(negedge clk);
    endtask

    task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic icin, input logic isub);
        logic [17:0] r;
        int t0;
        int n = 0;
        r = ref_op(4, {12'h000, ia}, {12'h000, ib}, icin, isub);
        s4_a = ia; s4_b = ib; s4_cin = icin; s4_sub = isub; s4_start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        s4_start = 1'b0;
        s4_a = 4'($urandom); s4_b = 4'($urandom);
        while (s4_done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (s4_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL w4_timeout: got no done expected done within 10 cycles");
        end else begin
            check("w4_latency", 32'(cyc - t0), 32'd1);
            check("w4_sum", 32'(s4_sum), 32'(r[3:0]));
            check("w4_cout", 32'(s4_cout), 32'(r[16]));
            check("w4_ovf", 32'(s4_ovf), 32'(r[17]));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        s16_start = 1'b0; s16_a = '0; s16_b = '0; s16_cin = 1'b0; s16_sub = 1'b0;
        s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_cin = 1'b0; s4_sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, issued back to back; one carries a mid-RUN start poke.
        issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1);
        issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 1'b1);
        end
        issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();

        // Reset one cycle after an accepted start abandons the operation.
        issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        run4(4'hF, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
